// File: rtl/xy_router_pkg.sv
// Shared port indices, flit field offsets and the XY route decision.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package xy_router_pkg;

  localparam int NUM_PORTS   = 5;
  localparam int P_L         = 0;
  localparam int P_N         = 1;
  localparam int P_E         = 2;
  localparam int P_S         = 3;
  localparam int P_W         = 4;

  // Coordinates are widened to this before comparison so one function
  // serves every COORD_W the router is built with.
  localparam int COORD_MAX_W = 16;

  typedef logic [COORD_MAX_W-1:0] coord_t;
  typedef logic [NUM_PORTS-1:0]   dir_t;

  // Flit layout is {dst_y, dst_x, payload}; payload starts at bit 0.
  function automatic int dst_x_lsb(input int payload_w);
    return payload_w;
  endfunction

  function automatic int dst_y_lsb(input int payload_w, input int coord_w);
    return payload_w + coord_w;
  endfunction

  // Dimension-ordered routing: resolve X fully before Y, deliver locally
  // when both match. Result is one-hot over the port indices.
  function automatic dir_t route_xy(input coord_t dst_x, input coord_t dst_y,
                                    input coord_t cur_x, input coord_t cur_y);
    dir_t dir;
    dir = '0;
    if (dst_x > cur_x)      dir[P_E] = 1'b1;
    else if (dst_x < cur_x) dir[P_W] = 1'b1;
    else if (dst_y > cur_y) dir[P_N] = 1'b1;
    else if (dst_y < cur_y) dir[P_S] = 1'b1;
    else                    dir[P_L] = 1'b1;
    return dir;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own pointer register, one per router output.
// Latency: grant is combinational from request and pointer; pointer updates on the edge.
// Backpressure: pointer only moves when i_adv is high and a grant is issued.
module rr_arbiter #(
  parameter int  N  = 5,
  localparam int PW = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic [N-1:0] o_gnt
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;

  // Scan requesters starting at the pointer, wrapping mod N (not mod 2^PW).
  always_comb begin
    logic          w_found;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    o_gnt      = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        w_next_ptr   = (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  // Pointer moves past the winner only when the grant is actually consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst)                r_ptr <= '0;
    else if (i_adv && |i_req) r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/xy_mesh_router.sv
// 5-port XY mesh router: per-input FIFO, per-output round-robin arbiter, registered output stage.
// Latency: flit pushed at edge t is presented on its output after edge t+1 when the output is free.
// Backpressure: in_ready is FIFO-not-full from the registered count; an output reloads only when empty or accepted.
module xy_mesh_router
  import xy_router_pkg::*;
#(
  parameter int  COORD_W    = 4,
  parameter int  PAYLOAD_W  = 16,
  parameter int  FIFO_DEPTH = 2,
  localparam int FLIT_W     = PAYLOAD_W + 2*COORD_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [COORD_W-1:0]          i_cur_x,
  input  logic [COORD_W-1:0]          i_cur_y,
  input  logic [NUM_PORTS-1:0]        i_in_valid,
  output logic [NUM_PORTS-1:0]        o_in_ready,
  input  logic [NUM_PORTS*FLIT_W-1:0] i_in_data,
  output logic [NUM_PORTS-1:0]        o_out_valid,
  input  logic [NUM_PORTS-1:0]        i_out_ready,
  output logic [NUM_PORTS*FLIT_W-1:0] o_out_data
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int DX_LSB = dst_x_lsb(PAYLOAD_W);
  localparam int DY_LSB = dst_y_lsb(PAYLOAD_W, COORD_W);

  logic [NUM_PORTS-1:0][FLIT_W-1:0]    w_head;
  logic [NUM_PORTS-1:0]                w_empty;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_dir;   // [input][output]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_gnt;   // [output][input]
  logic [NUM_PORTS-1:0]                w_load;
  logic [NUM_PORTS-1:0]                w_pop;

  // ---------------------------------------------------------------- inputs
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [FLIT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic              w_push;

    assign o_in_ready[p] = (r_cnt != CW'(FIFO_DEPTH));
    assign w_push        = i_in_valid[p] & o_in_ready[p];
    assign w_empty[p]    = (r_cnt == '0);
    assign w_head[p]     = r_mem[r_rd_ptr];
    assign w_dir[p]      = w_empty[p] ? '0 :
                           route_xy(coord_t'(w_head[p][DX_LSB +: COORD_W]),
                                    coord_t'(w_head[p][DY_LSB +: COORD_W]),
                                    coord_t'(i_cur_x), coord_t'(i_cur_y));

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[p]) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop[p])      r_cnt <= r_cnt + 1'b1;
        else if (!w_push && w_pop[p]) r_cnt <= r_cnt - 1'b1;
      end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_in_data[p*FLIT_W +: FLIT_W];
    end
  end

  // --------------------------------------------------------------- outputs
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0] w_req;
    logic [FLIT_W-1:0]    w_sel;
    logic                 r_vld;
    logic [FLIT_W-1:0]    r_dat;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
      assign w_req[p] = w_dir[p][o];
    end

    assign w_load[o] = ~r_vld | i_out_ready[o];

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_req (w_req),
      .i_adv (w_load[o]),
      .o_gnt (w_gnt[o])
    );

    // One-hot AND-OR select of the winning head flit.
    always_comb begin
      w_sel = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_sel = w_sel | ({FLIT_W{w_gnt[o][p]}} & w_head[p]);
      end
    end

    // Output register: hold while stalled, otherwise take the winner or go idle.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else if (w_load[o]) begin
        r_vld <= |w_gnt[o];
        if (|w_gnt[o]) r_dat <= w_sel;
      end
    end

    assign o_out_valid[o]                 = r_vld;
    assign o_out_data[o*FLIT_W +: FLIT_W] = r_dat;
  end

  // An input pops when the output its head targets consumes the grant.
  always_comb begin
    w_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_load[o] && w_gnt[o][p]) w_pop[p] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xy_mesh_router.sv
// Self-checking bench for xy_mesh_router: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_xy_mesh_router;

  localparam int N     = 5;
  localparam int FW    = 24;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      cur_x, cur_y;
  logic [N-1:0]    in_valid, in_ready, out_valid, out_ready;
  logic [N*FW-1:0] in_data, out_data;

  always #5 clk = ~clk;

  xy_mesh_router #(.COORD_W(4), .PAYLOAD_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cur_x     (cur_x),
    .i_cur_y     (cur_y),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data)
  );

  // ---------------- reference model
  logic [FW-1:0] mq [N][$];
  logic [FW-1:0] m_dat [N];
  bit            m_vld [N];
  int            m_ptr [N];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [FW-1:0] mk(input int dy, input int dx, input logic [15:0] pl);
    return {dy[3:0], dx[3:0], pl};
  endfunction

  // Spec rule: X first (E/W), then Y (N/S), else local.
  function automatic int xy_port(input logic [FW-1:0] f, input int cx, input int cy);
    int dx, dy;
    dx = int'(f[19:16]);
    dy = int'(f[23:20]);
    if (dx > cx) return 2;
    if (dx < cx) return 4;
    if (dy > cy) return 1;
    if (dy < cy) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      mq[p].delete();
      m_vld[p] = 1'b0;
      m_dat[p] = '0;
      m_ptr[p] = 0;
    end
  endtask

  task automatic model_step();
    bit do_push [N];
    bit popped  [N];
    int win, i;
    for (int p = 0; p < N; p++) begin
      do_push[p] = in_valid[p] && (mq[p].size() < DEPTH);
      popped[p]  = 1'b0;
    end
    for (int o = 0; o < N; o++) begin
      if (!m_vld[o] || out_ready[o]) begin
        win = -1;
        for (int k = 0; k < N; k++) begin
          i = (m_ptr[o] + k) % N;
          if (win < 0 && mq[i].size() > 0 && xy_port(mq[i][0], int'(cur_x), int'(cur_y)) == o)
            win = i;
        end
        if (win >= 0) begin
          m_dat[o]    = mq[win][0];
          m_vld[o]    = 1'b1;
          popped[win] = 1'b1;
          m_ptr[o]    = (win + 1) % N;
        end else begin
          m_vld[o] = 1'b0;
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      if (popped[p])  void'(mq[p].pop_front());
      if (do_push[p]) mq[p].push_back(in_data[p*FW +: FW]);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The single every-cycle compare against the model.
  task automatic compare_all();
    for (int p = 0; p < N; p++) begin
      chk($sformatf("in_ready[%0d]", p), 64'(in_ready[p]), 64'(mq[p].size() < DEPTH));
      chk($sformatf("out_valid[%0d]", p), 64'(out_valid[p]), 64'(m_vld[p]));
      if (m_vld[p])
        chk($sformatf("out_data[%0d]", p), 64'(out_data[p*FW +: FW]), 64'(m_dat[p]));
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [2:0] src_of(input int o);
    logic [FW-1:0] f;
    f = out_data[o*FW +: FW];
    return f[15:13];
  endfunction

  int seq, exp_seq;
  bit pushed;

  initial begin
    rst = 1'b1; cur_x = 4'd3; cur_y = 4'd3; out_ready = '1;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1f);
    chk("reset_out_data", 64'(out_data), 64'h0);
    rst = 1'b0;

    // Local loop
    in_valid = 5'b00001;
    in_data[0*FW +: FW] = mk(3, 3, 16'hBEEF);
    tick();
    idle_inputs();
    chk("loop_not_yet", 64'(out_valid), 64'h0);
    tick();
    chk("loop_valid", 64'(out_valid), 64'h01);
    chk("loop_data", 64'(out_data[0 +: FW]), 64'h33BEEF);
    tick();

    // X-first routing
    in_valid = 5'b11010;
    in_data[1*FW +: FW] = mk(1, 5, 16'h1111);
    in_data[3*FW +: FW] = mk(7, 3, 16'h3333);
    in_data[4*FW +: FW] = mk(9, 0, 16'h4444);
    tick();
    idle_inputs();
    tick();
    chk("xfirst_valid", 64'(out_valid), 64'h16);
    chk("xfirst_E", 64'(out_data[2*FW +: FW]), 64'h151111);
    chk("xfirst_N", 64'(out_data[1*FW +: FW]), 64'h733333);
    chk("xfirst_W", 64'(out_data[4*FW +: FW]), 64'h904444);
    tick();

    // Contention: everyone to E, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < N; p++) begin
        in_valid[p] = 1'b1;
        in_data[p*FW +: FW] = mk(0, 5, {p[2:0], 13'h0});
      end
      tick();
      idle_inputs();
      for (int k = 0; k < N; k++) begin
        tick();
        chk($sformatf("contend_r%0d_valid%0d", r, k), 64'(out_valid[2]), 64'h1);
        chk($sformatf("contend_r%0d_src%0d", r, k), 64'(src_of(2)), 64'(k));
      end
      tick();
    end

    // Backpressure on E with the E input streaming into E
    out_ready = 5'b11011;
    seq = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 5'b00100;
      in_data[2*FW +: FW] = mk(0, 5, 16'(seq));
      pushed = in_ready[2];
      tick();
      if (pushed) seq++;
    end
    chk("bp_in_ready_low", 64'(in_ready[2]), 64'h0);
    chk("bp_queued", 64'(seq), 64'd3);
    chk("bp_hold_data", 64'(out_data[2*FW +: 16]), 64'h0);
    out_ready = '1;
    exp_seq = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        in_valid = 5'b00100;
        in_data[2*FW +: FW] = mk(0, 5, 16'(seq));
      end else begin
        idle_inputs();
      end
      pushed = in_valid[2] && in_ready[2];
      if (out_valid[2] && out_ready[2]) begin
        chk("bp_order", 64'(out_data[2*FW +: 16]), 64'(exp_seq));
        exp_seq++;
      end
      tick();
      if (pushed) seq++;
    end
    chk("bp_no_loss", 64'(exp_seq), 64'(seq));

    // Reset mid-traffic
    out_ready = '0;
    in_valid = 5'b00111;
    in_data[0*FW +: FW] = mk(5, 3, 16'h0001);
    in_data[1*FW +: FW] = mk(3, 5, 16'h2001);
    in_data[2*FW +: FW] = mk(3, 0, 16'h4001);
    tick();
    tick();
    chk("midrst_pre_valid", 64'(out_valid), 64'h16);
    do_reset();
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_ready", 64'(in_ready), 64'h1f);
    out_ready = '1;
    in_valid = 5'b10001;
    in_data[0*FW +: FW] = mk(0, 5, 16'h0000);
    in_data[4*FW +: FW] = mk(0, 5, 16'h8000);
    tick();
    idle_inputs();
    tick();
    chk("midrst_first_src", 64'(src_of(2)), 64'h0);
    tick();
    tick();

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      if (c % 2500 == 1250) begin
        do_reset();
        cur_x = 4'($urandom_range(0, 15));
        cur_y = 4'($urandom_range(0, 15));
      end
      for (int p = 0; p < N; p++) begin
        in_valid[p]  = ($urandom_range(0, 99) < 45);
        in_data[p*FW +: FW] = mk($urandom_range(0, 15), $urandom_range(0, 15),
                                 {p[2:0], 13'($urandom)});
        out_ready[p] = ($urandom_range(0, 99) < 70);
      end
      tick();
    end
    idle_inputs();
    out_ready = '1;
    for (int c = 0; c < 20; c++) tick();
    for (int p = 0; p < N; p++)
      chk($sformatf("drained[%0d]", p), 64'(mq[p].size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xy_mesh_router.md
# xy_mesh_router

Registered 5-port XY dimension-ordered mesh router, the sequential, parametrised successor to the combinational route-decision logic in the benchmark set. Each port (Local, North, East, South, West) has an input FIFO. Head-of-line flits are routed by comparing destination against the node's own coordinates. Each output has its own round-robin arbiter and a registered valid/ready output stage. One instance sits at every node of a 2-D mesh.

## Interface
Parameters:
- COORD_W, 4: width of each X/Y coordinate field.
- PAYLOAD_W, 16: payload bits per flit.
- FIFO_DEPTH, 2: entries per input FIFO, power of two, ≥2.
- FLIT_W, PAYLOAD_W+2*COORD_W: derived. Flit layout is {dst_y, dst_x, payload}.

Ports (port index p: 0=L, 1=N, 2=E, 3=S, 4=W; flat buses are slice p = bits [p*FLIT_W +: FLIT_W]):
- clk, in, 1: single clock, all state changes on rising edge.
- rst, in, 1: synchronous, active-high reset.
- cur_x, in, COORD_W: this node's X; quasi-static.
- cur_y, in, COORD_W: this node's Y; quasi-static.
- in_valid, in, 5: per-port flit valid.
- in_ready, out, 5: per-port FIFO not full.
- in_data, in, 5*FLIT_W: per-port flit.
- out_valid, out, 5: per-port output register occupied.
- out_ready, in, 5: downstream accepts.
- out_data, out, 5*FLIT_W: per-port registered flit.

## Operation
- Input FIFO p pushes on in_valid[p]&in_ready[p].
  - in_ready[p] = !full[p], from registered count only. It does not look ahead at a same-cycle pop.
- Route of a head flit, unsigned compare, X first:
  - dst_x>cur_x → E; dst_x<cur_x → W.
  - else dst_y>cur_y → N; dst_y<cur_y → S.
  - else L.
- No U-turn filtering: the flit goes wherever the route says, including back out of its input port.
- Per output o, the requesters are the non-empty inputs whose head routes to o.
  - Output o may load when !out_valid[o] | out_ready[o].
  - If it may load, a round-robin grant selects one requester. The winner pops its FIFO and its flit is written to out_data[o]; out_valid[o] is set.
  - If it may load and there are no requesters, out_valid[o] clears.
- Arbiter pointer: starts at 0 (priority order 0,1,2,3,4). After a grant to input i it moves to (i+1) mod 5. Without a grant it holds.
- Each input heads exactly one output, so one FIFO never pops twice per cycle.
- out_data holds stable while out_valid & !out_ready.
- Flits are single-flit packets. Per input→output pair, order is preserved.

## Timing
- Reset values:
  - All FIFOs empty, in_ready=5'b11111.
  - out_valid=0, out_data=0.
  - Arbiter pointers=0.
- Reset mid-operation discards every buffered flit with no output glitch. out_valid is 0 in the first cycle after rst.
- Latency: flit pushed at edge t, out_valid high after edge t+1. That is 1 cycle through an empty router with the output free, 2 edges from the input handshake.
- Throughput: 1 flit/cycle/output with out_ready held high.
- FIFO full: in_ready low the cycle after the push that filled it. It rises the cycle after a pop.
- Simultaneous push and pop on a full FIFO cannot occur, because in_ready=0. On a non-full FIFO, push and pop together leave the count unchanged.
- Pointer arithmetic wraps mod 5, not mod 8.
- FIFO pointers wrap mod FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits.

## Structure
- Package xy_router_pkg holds:
  - Port index constants P_L..P_W and NUM_PORTS=5.
  - Flit field offset functions.
  - The route function (dst, cur → one-hot 5-bit direction).
- Sub-module rr_arbiter (N=5): inputs are request, advance and the pointer register; output is a one-hot grant. Five instances are used, one per output.
- FIFO storage is inline, as a generate loop over ports.

## Test plan
- Local loop: cur=(3,3), inject on L a flit with dst=(3,3), payload 0xBEEF → out_valid[L] after 1 cycle, out_data payload 0xBEEF. The other outputs stay 0.
- X-first: cur=(3,3), N input sends dst=(5,1) → exits E. S input sends dst=(3,7) → exits N. W input sends dst=(0,9) → exits W.
- Contention: all 5 inputs send flits routed to E in the same cycle, out_ready[E]=1 → grants in order 0,1,2,3,4 on 5 consecutive cycles. The next contention starts at 0.
- Backpressure: out_ready[E]=0 for 6 cycles while E input streams flits routed to E → out_data[E] stable. in_ready[E] drops once FIFO_DEPTH flits are queued behind the output register. No loss and order kept after release.
- Reset mid-traffic: assert rst with 3 FIFOs non-empty and out_valid=5'b10110 → next cycle out_valid=0 and in_ready=5'b11111. The first new flit routes with pointer 0.
- Random traffic, 10k cycles, random out_ready: a scoreboard checks every flit exits the XY-correct port exactly once, in per-pair order.
